rob_multiport: RTL

- Parametrised reorder buffer. Successor to the fixed 16-entry, 2-issue/3-complete/2-retire completion stage.
- Allocates entries in program order at dispatch and records out-of-order FU completions.
- Retires a contiguous prefix of completed entries in order, up to RETIRE_W per cycle.
- Adds head/tail/count occupancy tracking, dispatch backpressure, retire stall, flush and a spurious-completion flag.
- Sits between rename/dispatch, the FU completion buses and the commit/free-list logic.

---
 rtl/rob_multiport_pkg.sv | 34 +++
 rtl/rob_multiport_chk.sv | 26 ++
 rtl/rob_retire_select.sv | 34 +++
 rtl/rob_multiport.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rob_multiport_pkg.sv
// Shared types for the multiport reorder buffer: dispatch payload, retired-entry record
// and the index-width helper.
package rob_multiport_pkg;

    localparam int ROB_DATA_W      = 32;
    localparam int ROB_PREG_W      = 6;
    localparam int ROB_IDX_FIELD_W = 8;

    function automatic int rob_idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic [ROB_PREG_W-1:0] preg_addr_dst;
        logic [ROB_PREG_W-1:0] old_preg_addr_dst;
        logic                  reg_write;
        logic                  mem_write;
        logic                  mem_to_reg;
    } rob_disp_t;

    // Index is zero-extended so the record layout does not depend on DEPTH.
    typedef struct packed {
        logic                       valid;
        logic                       complete;
        logic [ROB_PREG_W-1:0]      preg_addr_dst;
        logic [ROB_PREG_W-1:0]      old_preg_addr_dst;
        logic [ROB_DATA_W-1:0]      data;
        logic                       reg_write;
        logic                       mem_write;
        logic                       mem_to_reg;
        logic [ROB_IDX_FIELD_W-1:0] index;
    } rob_entry_t;

endpackage

// File: rtl/rob_multiport_chk.sv
// Parameter legality and occupancy-bound checks for rob_multiport.
module rob_multiport_chk
    import rob_multiport_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = ROB_DATA_W,
    parameter int PREG_W = ROB_PREG_W,
    parameter int IDX_W  = rob_idx_w(DEPTH)
) (
    input logic             i_clk,
    input logic             i_rst_n,
    input logic [IDX_W:0]   i_count
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rob_multiport: DEPTH must be a power of two >= 4");
    end
    if (DATA_W != ROB_DATA_W || PREG_W != ROB_PREG_W || IDX_W > ROB_IDX_FIELD_W) begin : g_bad_width
        $error("rob_multiport: widths disagree with rob_multiport_pkg");
    end

    // Occupancy must never exceed the number of entries.
    a_count_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_count <= (IDX_W+1)'(DEPTH));

endmodule

// File: rtl/rob_retire_select.sv
// In-order retire scan: counts the contiguous valid+complete run starting at head,
// capped at RETIRE_W, and reports the index each retire lane would take.
module rob_retire_select
    import rob_multiport_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int RETIRE_W = 2,
    parameter int IDX_W    = rob_idx_w(DEPTH),
    parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
    input  logic [DEPTH-1:0]               i_valid,
    input  logic [DEPTH-1:0]               i_complete,
    input  logic [IDX_W-1:0]               i_head,
    output logic [CNT_W-1:0]               o_ret_n,
    output logic [RETIRE_W-1:0][IDX_W-1:0] o_ret_idx
);

    logic w_run;

    // Prefix scan; the run breaks at the first entry that is not ready to retire.
    always_comb begin
        o_ret_n = '0;
        w_run   = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            o_ret_idx[k] = i_head + IDX_W'(k);
            if (w_run && i_valid[o_ret_idx[k]] && i_complete[o_ret_idx[k]]) begin
                o_ret_n = o_ret_n + CNT_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer: in-order allocation, out-of-order completion,
// in-order retirement of up to RETIRE_W entries per cycle.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DISPATCH_W = 2,
    parameter int COMPLETE_W = 3,
    parameter int RETIRE_W   = 2,
    parameter int DATA_W     = ROB_DATA_W,
    parameter int PREG_W     = ROB_PREG_W,
    localparam int IDX_W     = rob_idx_w(DEPTH)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_flush,
    input  logic [DISPATCH_W-1:0]                i_disp_valid,
    input  rob_disp_t [DISPATCH_W-1:0]           i_disp_info,
    output logic                                 o_disp_ready,
    output logic [DISPATCH_W-1:0][IDX_W-1:0]     o_disp_idx,
    input  logic [COMPLETE_W-1:0]                i_cmp_valid,
    input  logic [COMPLETE_W-1:0][IDX_W-1:0]     i_cmp_idx,
    input  logic [COMPLETE_W-1:0][DATA_W-1:0]    i_cmp_data,
    input  logic                                 i_ret_ready,
    output logic [RETIRE_W-1:0]                  o_ret_valid,
    output rob_entry_t [RETIRE_W-1:0]            o_ret_entry,
    output logic [IDX_W:0]                       o_count,
    output logic                                 o_empty,
    output logic                                 o_full,
    output logic                                 o_err_spurious
);

    localparam int DCNT_W = $clog2(DISPATCH_W + 1);
    localparam int RCNT_W = $clog2(RETIRE_W + 1);

    logic [DEPTH-1:0]              r_valid;
    logic [DEPTH-1:0]              r_complete;
    rob_disp_t                     r_info [DEPTH];
    logic [DATA_W-1:0]             r_data [DEPTH];
    logic [IDX_W-1:0]              r_head;
    logic [IDX_W-1:0]              r_tail;
    logic [IDX_W:0]                r_count;
    logic [RETIRE_W-1:0]           r_ret_valid;
    rob_entry_t [RETIRE_W-1:0]     r_ret_entry;
    logic                          r_err_spurious;

    logic [DCNT_W-1:0]             w_disp_n;
    logic [DCNT_W-1:0]             w_acc_n;
    logic [RCNT_W-1:0]             w_ret_n;
    logic [RCNT_W-1:0]             w_ret_take;
    logic [RETIRE_W-1:0][IDX_W-1:0] w_ret_idx;
    rob_entry_t [RETIRE_W-1:0]     w_ret_entry;
    logic [COMPLETE_W-1:0]         w_cmp_hit;
    logic                          w_dup;
    logic                          w_spur;

    // Backpressure looks only at registered occupancy; same-cycle retirements earn no credit.
    assign o_disp_ready   = ((IDX_W+1)'(DEPTH) - r_count) >= (IDX_W+1)'(DISPATCH_W);
    assign w_acc_n        = o_disp_ready ? w_disp_n : '0;
    assign w_ret_take     = i_ret_ready ? w_ret_n : '0;
    assign o_count        = r_count;
    assign o_empty        = (r_count == '0);
    assign o_full         = (r_count == (IDX_W+1)'(DEPTH));
    assign o_ret_valid    = r_ret_valid;
    assign o_ret_entry    = r_ret_entry;
    assign o_err_spurious = r_err_spurious;

    rob_retire_select #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W),
        .IDX_W    (IDX_W),
        .CNT_W    (RCNT_W)
    ) u_retire_select (
        .i_valid    (r_valid),
        .i_complete (r_complete),
        .i_head     (r_head),
        .o_ret_n    (w_ret_n),
        .o_ret_idx  (w_ret_idx)
    );

    rob_multiport_chk #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PREG_W (PREG_W),
        .IDX_W  (IDX_W)
    ) u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_count (r_count)
    );

    // Dispatch lane indices: packed after tail in lane order, skipping idle lanes.
    always_comb begin
        w_disp_n = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            o_disp_idx[k] = r_tail + IDX_W'(w_disp_n);
            w_disp_n      = w_disp_n + DCNT_W'(i_disp_valid[k]);
        end
    end

    // Completion filter: start-of-cycle validity gates the write; a higher lane beats a duplicate.
    always_comb begin
        w_cmp_hit = '0;
        w_spur    = 1'b0;
        w_dup     = 1'b0;
        for (int k = 0; k < COMPLETE_W; k++) begin
            w_dup = 1'b0;
            for (int j = k + 1; j < COMPLETE_W; j++) begin
                w_dup = w_dup | (i_cmp_valid[j] && (i_cmp_idx[j] == i_cmp_idx[k]));
            end
            if (i_cmp_valid[k]) begin
                w_cmp_hit[k] = r_valid[i_cmp_idx[k]] && !w_dup;
                w_spur       = w_spur | !r_valid[i_cmp_idx[k]] | w_dup;
            end else begin
                w_cmp_hit[k] = 1'b0;
            end
        end
    end

    // Retire record assembled from the entries the scan selected.
    always_comb begin
        for (int k = 0; k < RETIRE_W; k++) begin
            w_ret_entry[k].valid             = 1'b1;
            w_ret_entry[k].complete          = 1'b1;
            w_ret_entry[k].preg_addr_dst     = r_info[w_ret_idx[k]].preg_addr_dst;
            w_ret_entry[k].old_preg_addr_dst = r_info[w_ret_idx[k]].old_preg_addr_dst;
            w_ret_entry[k].data              = r_data[w_ret_idx[k]];
            w_ret_entry[k].reg_write         = r_info[w_ret_idx[k]].reg_write;
            w_ret_entry[k].mem_write         = r_info[w_ret_idx[k]].mem_write;
            w_ret_entry[k].mem_to_reg        = r_info[w_ret_idx[k]].mem_to_reg;
            w_ret_entry[k].index             = ROB_IDX_FIELD_W'(w_ret_idx[k]);
        end
    end

    // Control state: flush behaves as reset but leaves the error flag alone.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_valid     <= '0;
            r_complete  <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_ret_valid <= '0;
        end else begin
            for (int k = 0; k < RETIRE_W; k++) begin
                if (RCNT_W'(k) < w_ret_take) begin
                    r_valid[w_ret_idx[k]] <= 1'b0;
                end
                r_ret_valid[k] <= (RCNT_W'(k) < w_ret_take);
            end
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (o_disp_ready && i_disp_valid[k]) begin
                    r_valid[o_disp_idx[k]]    <= 1'b1;
                    r_complete[o_disp_idx[k]] <= 1'b0;
                end
            end
            for (int k = 0; k < COMPLETE_W; k++) begin
                if (w_cmp_hit[k]) begin
                    r_complete[i_cmp_idx[k]] <= 1'b1;
                end
            end
            r_head  <= r_head + IDX_W'(w_ret_take);
            r_tail  <= r_tail + IDX_W'(w_acc_n);
            r_count <= r_count + (IDX_W+1)'(w_acc_n) - (IDX_W+1)'(w_ret_take);
        end
    end

    // Sticky spurious-completion flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_spurious <= 1'b0;
        end else if (!i_flush && w_spur) begin
            r_err_spurious <= 1'b1;
        end
    end

    // Entry payload and retire capture; qualified by the valid bits, so no reset.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (o_disp_ready && i_disp_valid[k]) begin
                r_info[o_disp_idx[k]] <= i_disp_info[k];
            end
        end
        for (int k = 0; k < COMPLETE_W; k++) begin
            if (w_cmp_hit[k]) begin
                r_data[i_cmp_idx[k]] <= i_cmp_data[k];
            end
        end
        if (i_ret_ready) begin
            r_ret_entry <= w_ret_entry;
        end
    end

endmodule
